// File: rtl/serial_to_parallel_hs_pkg.sv
// Shared helpers for the serial-to-parallel deserializer: slot placement,
// counter width and parameter legality.
package s2p_pkg;

  // Base bit of beat slot k inside the output word.
  function automatic int s2p_slot_lsb(input int k, input int in_w, input int out_w,
                                      input bit msb_first);
    return msb_first ? out_w - (k + 1) * in_w : k * in_w;
  endfunction

  function automatic int s2p_cnt_w(input int nbeats);
    return $clog2(nbeats + 1);
  endfunction

  function automatic bit s2p_params_ok(input int in_w, input int out_w);
    return (in_w >= 1) && (out_w % in_w == 0) && (out_w / in_w >= 2);
  endfunction

endpackage

// File: rtl/serial_to_parallel_hs_if.sv
// Beat-in / word-out handshake bundle. slave = deserializer, master = its environment.
interface serial_to_parallel_hs_if
  import s2p_pkg::*;
#(
  parameter int IN_WIDTH  = 1,
  parameter int OUT_WIDTH = 8
);
  localparam int CNT_W = s2p_cnt_w(OUT_WIDTH / IN_WIDTH);

  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]     out_count;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_last, out_valid
  );
endinterface

// File: rtl/serial_to_parallel_hs_word_reg.sv
// Single-entry output holding register; slot_free tells the packer a closing
// beat may be taken this cycle.
module s2p_word_reg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              last_o,
  output logic              slot_free_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_q;
  logic              last_q;

  assign slot_free_o = !valid_q | ready_i;

  // Load wins over the drain so back-to-back words keep valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      count_q <= count_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign last_o  = last_q;
endmodule

// File: rtl/serial_to_parallel_hs.sv
// Packs IN_WIDTH-bit beats into OUT_WIDTH-bit words, closing a word when it
// fills or early on in_last; the held word sits in s2p_word_reg.
module serial_to_parallel_hs
  import s2p_pkg::*;
#(
  parameter int IN_WIDTH  = 1,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_to_parallel_hs_if.slave  bus
);
  localparam int NBEATS = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W  = s2p_cnt_w(NBEATS);

  if (!s2p_params_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_params
    $fatal(1, "serial_to_parallel_hs: OUT_WIDTH must be a multiple >= 2 of IN_WIDTH");
  end

  logic [OUT_WIDTH-1:0] acc_q, acc_d, beat_w, merged;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 slot_free, last_slot, closing, accept, load;

  assign last_slot    = (cnt_q == CNT_W'(NBEATS - 1));
  assign closing      = last_slot | bus.in_last;
  // Only a closing beat needs room downstream; others always accumulate.
  assign bus.in_ready = slot_free | !closing;
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = accept & closing;

  for (genvar k = 0; k < NBEATS; k++) begin : g_slot
    localparam int LSB = s2p_slot_lsb(k, IN_WIDTH, OUT_WIDTH, MSB_FIRST);
    assign beat_w[LSB +: IN_WIDTH] = (cnt_q == CNT_W'(k)) ? bus.in_data : '0;
  end

  // acc only ever holds filled slots, so unfilled ones are already zero.
  assign merged = acc_q | beat_w;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (closing) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  s2p_word_reg #(.DATA_W(OUT_WIDTH), .CNT_W(CNT_W)) u_word_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .data_i      (merged),
    .count_i     (cnt_q + CNT_W'(1)),
    .last_i      (bus.in_last),
    .ready_i     (bus.out_ready),
    .valid_o     (bus.out_valid),
    .data_o      (bus.out_data),
    .count_o     (bus.out_count),
    .last_o      (bus.out_last),
    .slot_free_o (slot_free)
  );
endmodule
